// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read controller between synch_fifo and a valid/ready stream
//
// Pops words from a synch_fifo and replays them as bursts on a valid/ready
// master stream. A burst starts once BURST_LEN words are available, or once a
// partial amount has sat in the FIFO for TIMEOUT cycles. The burst length is
// frozen at the start of the burst.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   fifo_rden        pop request to synch_fifo (combinational)
//   fifo_rddata      pop data, valid the cycle after fifo_rden
//   fifo_empty       synch_fifo empty flag
//   fifo_data_avail  synch_fifo occupancy
//   m_valid/m_ready  stream handshake
//   m_data, m_last   stream beat data and end-of-burst marker
//   busy             high while a burst is in progress
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_PTR   = 4,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = FIFO_PTR + 1;
  localparam logic [CW-1:0] BURST_LEN_C  = CW'(BURST_LEN);
  localparam logic [CW-1:0] ONE_C        = CW'(1);
  localparam logic [7:0]    TIMEOUT_M1_C = 8'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              timer_q, timer_d;
  logic [CW-1:0]           rd_left_q, rd_left_d;
  logic [CW-1:0]           tx_left_q, tx_left_d;
  logic [1:0]              buf_count_q, buf_count_d;
  logic [FIFO_WIDTH-1:0]   buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0]   buf1_q, buf1_d;
  logic                    inflight_q, inflight_d;

  logic                    handshake;
  logic                    start_burst;
  logic                    last_hs;
  logic [CW-1:0]           burst_len;
  logic [2:0]              occ_after;

  // Shared decode used by both the FSM and the datapath.
  always_comb begin
    handshake   = (buf_count_q != 2'd0) & m_ready;
    start_burst = (state_q == ST_IDLE) &
                  ((fifo_data_avail >= BURST_LEN_C) |
                   ((timer_q == TIMEOUT_M1_C) & ~fifo_empty));
    burst_len   = (fifo_data_avail >= BURST_LEN_C) ? BURST_LEN_C : fifo_data_avail;
    last_hs     = handshake & (tx_left_q == ONE_C);
    // Words that will still be held after this cycle's pop; a new read is
    // allowed only if it cannot push the total past two.
    occ_after   = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, handshake};
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_burst) state_d = ST_BURST;
      ST_BURST: if (last_hs)     state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The read request is gated by reset so nothing is popped
  // from the FIFO during a reset cycle.
  always_comb begin
    busy      = (state_q == ST_BURST);
    fifo_rden = rst_n & (state_q == ST_BURST) & (rd_left_q != '0) &
                ~fifo_empty & (occ_after < 3'd2);
    m_valid   = (buf_count_q != 2'd0);
    m_data    = buf0_q;
    m_last    = (buf_count_q != 2'd0) & (tx_left_q == ONE_C);
  end

  // Datapath next-state: idle timer, beat counters and the two-entry skid
  // buffer. buf0 is always the head, so m_data only moves on a pop or when an
  // empty buffer is filled.
  always_comb begin
    timer_d     = timer_q;
    rd_left_d   = rd_left_q;
    tx_left_d   = tx_left_q;
    buf_count_d = buf_count_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    inflight_d  = fifo_rden;

    if (state_q == ST_IDLE) begin
      if (start_burst || fifo_empty) begin
        timer_d = 8'd0;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end else begin
      timer_d = 8'd0;
    end

    if (start_burst) begin
      rd_left_d = burst_len;
      tx_left_d = burst_len;
    end else begin
      if (fifo_rden) rd_left_d = rd_left_q - ONE_C;
      if (handshake) tx_left_d = tx_left_q - ONE_C;
    end

    case ({inflight_q, handshake})
      2'b10: begin
        if (buf_count_q == 2'd0) buf0_d = fifo_rddata;
        else                     buf1_d = fifo_rddata;
        buf_count_d = buf_count_q + 2'd1;
      end
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together: count is unchanged, the head advances.
        if (buf_count_q == 2'd1) begin
          buf0_d = fifo_rddata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rddata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q     <= 8'd0;
      rd_left_q   <= '0;
      tx_left_q   <= '0;
      buf_count_q <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      inflight_q  <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      rd_left_q   <= rd_left_d;
      tx_left_q   <= tx_left_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  localparam int W  = 32;
  localparam int P  = 4;
  localparam int BL = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata;
  logic         fifo_empty;
  logic [P:0]   fifo_data_avail;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .FIFO_WIDTH(W), .FIFO_PTR(P), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata),
    .fifo_empty(fifo_empty), .fifo_data_avail(fifo_data_avail),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural synch_fifo and scoreboard of words popped but not yet delivered.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] popped_q[$];

  // Values sampled at the falling edge.
  logic         s_rden, s_valid, s_last, s_busy, s_ready;
  logic [W-1:0] s_data;

  // Monitor history.
  logic         prev_valid = 0, prev_ready = 0, prev_last = 0, prev_busy = 0;
  logic [W-1:0] prev_data = '0;
  int           prev_avail = 0;
  int           exp_len = 0, beat_idx = 0;
  logic         drop_pending = 0;
  int           hs_total = 0, last_total = 0;

  typedef struct {
    logic         ready;
    logic         rden;
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         busy;
  } vec_t;
  vec_t tv[8];

  int first_idx, base_hs, base_last, pushed5, delivered5;
  logic [W-1:0] got_data[2];
  logic         got_last[2];
  int           got_n;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic update_flags();
    fifo_empty      = (fifo_q.size() == 0);
    fifo_data_avail = (P+1)'(fifo_q.size());
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    update_flags();
  endtask

  // Protocol and ordering checks applied every cycle out of reset.
  task automatic monitor();
    chk("rden_while_empty", {31'd0, s_rden & fifo_empty}, 0);
    chk("rden_while_idle", {31'd0, s_rden & ~s_busy}, 0);
    chk("held_le_2", {31'd0, popped_q.size() <= 2}, 1);
    chk("last_without_valid", {31'd0, s_last & ~s_valid}, 0);
    if (prev_valid && !prev_ready) begin
      chk("stall_valid", {31'd0, s_valid}, 1);
      chk("stall_data", s_data, prev_data);
      chk("stall_last", {31'd0, s_last}, {31'd0, prev_last});
    end
    if (drop_pending) begin
      chk("busy_drop_after_last", {31'd0, s_busy}, 0);
      drop_pending = 0;
    end
    if (s_busy && !prev_busy) begin
      exp_len  = imin(BL, prev_avail);
      beat_idx = 0;
    end
    if (s_valid && s_ready) begin
      beat_idx++;
      hs_total++;
      chk("beat_has_word", {31'd0, popped_q.size() != 0}, 1);
      if (popped_q.size() != 0) chk("beat_data_order", s_data, popped_q.pop_front());
      chk("beat_last", {31'd0, s_last}, {31'd0, beat_idx == exp_len});
      if (s_last) begin
        last_total++;
        drop_pending = 1;
      end
    end
    prev_valid = s_valid;
    prev_ready = s_ready;
    prev_data  = s_data;
    prev_last  = s_last;
    prev_busy  = s_busy;
    prev_avail = int'(fifo_data_avail);
  endtask

  // One clock: sample and check at the falling edge, then advance the FIFO
  // model just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_rden  = fifo_rden;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy;
    s_ready = m_ready;
    if (rst_n) monitor();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      popped_q.delete();
      prev_valid   = 0;
      prev_ready   = 0;
      prev_busy    = 0;
      drop_pending = 0;
    end else if (s_rden && fifo_q.size() != 0) begin
      fifo_rddata = fifo_q.pop_front();
      popped_q.push_back(fifo_rddata);
    end
    update_flags();
  endtask

  initial begin
    // Full-burst vectors: cycle 0 is the cycle right after four words land.
    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tv[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b1};
    tv[4] = '{1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b1};
    tv[5] = '{1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1};
    tv[6] = '{1'b1, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};

    rst_n       = 1'b0;
    m_ready     = 1'b0;
    fifo_rddata = '0;
    update_flags();

    // Reset with random inputs: every output held at zero.
    for (int i = 0; i < 3; i++) begin
      m_ready         = 1'($urandom_range(0, 1));
      fifo_empty      = 1'($urandom_range(0, 1));
      fifo_data_avail = (P+1)'($urandom_range(0, 16));
      fifo_rddata     = $urandom;
      tick();
      chk("reset_rden", {31'd0, s_rden}, 0);
      chk("reset_valid", {31'd0, s_valid}, 0);
      chk("reset_last", {31'd0, s_last}, 0);
      chk("reset_busy", {31'd0, s_busy}, 0);
      chk("reset_data", s_data, 0);
    end
    rst_n = 1'b1;

    // Full burst, table driven.
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      m_ready = tv[i].ready;
      tick();
      chk($sformatf("full_rden_c%0d", i), {31'd0, s_rden}, {31'd0, tv[i].rden});
      chk($sformatf("full_valid_c%0d", i), {31'd0, s_valid}, {31'd0, tv[i].valid});
      chk($sformatf("full_last_c%0d", i), {31'd0, s_last}, {31'd0, tv[i].last});
      chk($sformatf("full_busy_c%0d", i), {31'd0, s_busy}, {31'd0, tv[i].busy});
      if (tv[i].valid) chk($sformatf("full_data_c%0d", i), s_data, tv[i].data);
    end

    // Timeout flush of a two-word partial burst.
    m_ready = 1'b1;
    push_word(32'hC0);
    push_word(32'hC1);
    first_idx = -1;
    for (int i = 0; i < 40 && first_idx < 0; i++) begin
      tick();
      if (s_valid) first_idx = i;
    end
    chk("timeout_first_valid_cycle", 32'(first_idx), 32'(TO + 2));
    chk("timeout_beat1_data", s_data, 32'hC0);
    chk("timeout_beat1_last", {31'd0, s_last}, 0);
    tick();
    chk("timeout_beat2_data", s_data, 32'hC1);
    chk("timeout_beat2_last", {31'd0, s_last}, 1);
    for (int i = 0; i < 3; i++) tick();

    // Backpressure: eight words, random ready.
    base_hs   = hs_total;
    base_last = last_total;
    for (int i = 0; i < 8; i++) push_word(32'hD0 + 32'(i));
    for (int i = 0; i < 300 && (hs_total - base_hs) < 8; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("bp_beats", 32'(hs_total - base_hs), 8);
    chk("bp_bursts", 32'(last_total - base_last), 2);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Long random run followed by a drain.
    base_hs = hs_total;
    pushed5 = 0;
    for (int i = 0; i < 1000; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() < 16 && $urandom_range(0, 9) < 3) begin
        push_word($urandom);
        pushed5++;
      end
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200 && (fifo_q.size() != 0 || popped_q.size() != 0 || s_busy); i++) tick();
    delivered5 = hs_total - base_hs;
    chk("random_drain_fifo", 32'(fifo_q.size()), 0);
    chk("random_drain_held", 32'(popped_q.size()), 0);
    chk("random_all_delivered", 32'(delivered5), 32'(pushed5));
    for (int i = 0; i < 2; i++) tick();

    // Reset in the middle of a burst.
    base_hs = hs_total;
    for (int i = 0; i < 6; i++) push_word(32'hE0 + 32'(i));
    for (int i = 0; i < 60 && (hs_total - base_hs) < 2; i++) tick();
    chk("midrst_two_beats", 32'(hs_total - base_hs), 2);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, s_valid}, 0);
    chk("midrst_last", {31'd0, s_last}, 0);
    chk("midrst_busy", {31'd0, s_busy}, 0);
    chk("midrst_rden", {31'd0, s_rden}, 0);
    chk("midrst_data", s_data, 0);
    chk("midrst_fifo_left", 32'(fifo_q.size()), 2);
    m_ready = 1'b1;
    got_n   = 0;
    for (int i = 0; i < 60 && got_n < 2; i++) begin
      tick();
      if (s_valid && s_ready) begin
        got_data[got_n] = s_data;
        got_last[got_n] = s_last;
        got_n++;
      end
    end
    chk("midrst_new_beats", 32'(got_n), 2);
    if (got_n == 2) begin
      chk("midrst_beat1_data", got_data[0], 32'hE4);
      chk("midrst_beat1_last", {31'd0, got_last[0]}, 0);
      chk("midrst_beat2_data", got_data[1], 32'hE5);
      chk("midrst_beat2_last", {31'd0, got_last[1]}, 1);
    end
    for (int i = 0; i < 3; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
